// File: rtl/counter_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised counter family.
package counter_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Bits needed to hold the values 0..v-1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_next.sv
// Combinational next-count and flag logic for the up/down counter.
// Arithmetic is done one bit wider than the count so carries are visible.
module updown_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int STEP    = 1,
    parameter int SAT     = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic [WIDTH-1:0] nxt,
    output logic             ovf_nxt,
    output logic             unf_nxt
);

    localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] sum_x;

    always_comb begin
        cnt_x   = {1'b0, count};
        sum_x   = cnt_x + STEP_X;
        nxt     = count;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (up) begin
            if (sum_x <= MAX_X) begin
                nxt = WIDTH'(sum_x);
            end else if (SAT == MODE_SAT) begin
                // Already pinned at MAX: no new event, so no pulse.
                nxt     = WIDTH'(MAX_X);
                ovf_nxt = (cnt_x != MAX_X);
            end else begin
                nxt     = WIDTH'(sum_x - MOD_X);
                ovf_nxt = 1'b1;
            end
        end else begin
            if (cnt_x >= STEP_X) begin
                nxt = WIDTH'(cnt_x - STEP_X);
            end else if (SAT == MODE_SAT) begin
                nxt     = '0;
                unf_nxt = (cnt_x != '0);
            end else begin
                nxt     = WIDTH'(cnt_x + MOD_X - STEP_X);
                unf_nxt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: wrap or saturate, synchronous load, and
// registered one-cycle overflow/underflow pulses.
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int STEP    = 1,
    parameter int SAT     = MODE_WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MODULUS - 1);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be >= 2");
    end
    if (MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("updown_counter_param: MODULUS must be in 2..2**WIDTH");
    end
    if (STEP < 1 || STEP >= MODULUS) begin : g_bad_step
        $error("updown_counter_param: STEP must be in 1..MODULUS-1");
    end
    if (SAT != MODE_WRAP && SAT != MODE_SAT) begin : g_bad_sat
        $error("updown_counter_param: SAT must be 0 or 1");
    end

    logic [WIDTH-1:0] count_reg;
    logic             ovf_reg;
    logic             unf_reg;
    logic [WIDTH-1:0] step_nxt;
    logic             step_ovf;
    logic             step_unf;
    logic [WIDTH-1:0] load_clamped;

    updown_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP    (STEP),
        .SAT     (SAT)
    ) u_next (
        .count   (count_reg),
        .up      (up),
        .nxt     (step_nxt),
        .ovf_nxt (step_ovf),
        .unf_nxt (step_unf)
    );

    // Out-of-range loads clamp silently to MAX.
    assign load_clamped = ({1'b0, load_val} > MAX_X) ? WIDTH'(MAX_X) : load_val;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (load) begin
            count_reg <= load_clamped;
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end else if (en) begin
            count_reg <= step_nxt;
            ovf_reg   <= step_ovf;
            unf_reg   <= step_unf;
        end else begin
            ovf_reg   <= 1'b0;
            unf_reg   <= 1'b0;
        end
    end

    assign count  = count_reg;
    assign ovf    = ovf_reg;
    assign unf    = unf_reg;
    assign at_max = ({1'b0, count_reg} == MAX_X);
    assign at_min = (count_reg == '0);

endmodule
